simon_kexp_stream: RTL and testbench
====================================

// Module: simon_kexp_stream
// PURPOSE
//  Parametrised, iterative Simon key-schedule generator for all Simon word/key sizes.
//  Accepts one master key via a valid/ready handshake.
//  Streams round keys k[0..ROUNDS-1] one per accepted beat, over a valid/ready port with backpressure.
//  Feeds a round-serial Simon datapath directly; no flat expanded-key array is stored.
//  Only a KEY_WORDS-deep sliding window of words is held.
// PARAMETERS
//  WORD_W     32   Simon word size n; legal values 16,24,32,48,64.
//  KEY_WORDS  4    Key words m; legal values 2,3,4.
//  ROUNDS     44   Round keys T to emit; legal range KEY_WORDS..72.
//  Z_IDX      3    Simon z-sequence index j; legal range 0..4.
// PORTS
//  ck         in   1                   Clock; all logic on posedge.
//  rst        in   1                   Synchronous active-high reset.
//  key        in   WORD_W*KEY_WORDS    Master key; word w is key[w*WORD_W +: WORD_W] and equals k[w].
//  k_valid    in   1                   Key present.
//  k_ready    out  1                   Block idle, key may be accepted.
//  abort      in   1                   Synchronous abort of the current expansion.
//  rk_data    out  WORD_W              Current round key k[rk_index].
//  rk_index   out  7                   Round number of rk_data.
//  rk_valid   out  1                   rk_data/rk_index/rk_last valid.
//  rk_ready   in   1                   Consumer accepts round key.
//  rk_last    out  1                   High with rk_valid when rk_index==ROUNDS-1.
// BEHAVIOUR
//  Reset, held while rst=1:
//   - k_ready=0, rk_valid=0, rk_last=0, rk_index=0, rk_data=0.
//   - FSM in IDLE; window cleared.
//   - k_ready=1 from the first cycle after rst deasserts.
//  FSM states: IDLE, RUN.
//   - IDLE: k_ready=1, rk_valid=0.
//     - On k_valid&&k_ready: window W[0..m-1] <= key words 0..m-1, rk_index<=0, go RUN.
//     - rk_valid=1 with k[0] on the next cycle, i.e. 1-cycle accept-to-first-key latency.
//   - RUN: k_ready=0, rk_valid=1; rk_data=W[0], rk_index=i, where W holds k[i..i+m-1].
//     - Beat = rk_valid&&rk_ready.
//     - On a beat with i<ROUNDS-1: shift W[j]<=W[j+1], W[m-1]<=k[i+m], i<=i+1.
//     - On the beat with i==ROUNDS-1 (rk_last=1): go IDLE. rk_valid=0 and k_ready=1 on the next cycle.
//     - No beat: all outputs hold stable (AXI-style; data never changes while valid and not ready).
//  Schedule arithmetic, all mod 2^WORD_W:
//   - t = ror(W[m-1],3).
//   - If KEY_WORDS==4: t ^= W[1].
//   - t ^= ror(t,1).
//   - k[i+m] = ~W[0] ^ t ^ z_j[i mod 62] ^ 3, where ~ is the n-bit complement.
//   - z_j is the 62-bit sequence from the Simon specification. z_j[0] is the first (leftmost) published bit.
//   - The z pointer wraps 61->0.
//   - Computing k[i+m] past ROUNDS-1 is harmless; those words are never emitted.
//  Boundaries:
//   - k_valid while RUN: ignored, key not sampled; k_ready stays 0.
//   - Key accepted in the same cycle that returns to IDLE: impossible, because k_ready is registered low in RUN.
//   - abort=1 in RUN: next cycle IDLE, rk_valid=0, k_ready=1.
//     - A beat coincident with abort is consumed; no further keys are issued.
//     - abort in IDLE: no effect.
//   - rst mid-RUN: same as power-up reset; partial stream discarded.
//   - ROUNDS==KEY_WORDS: only the master-key words are emitted; no z bits are used.
//  Elaboration:
//   - An illegal parameter combination triggers $error at elaboration.
//   - Legal combos are all Simon variants: 32/64, 48/72, 48/96, 64/96, 64/128, 96/96, 96/144, 128/128, 128/192, 128/256.
// TESTING
//  1. rst 3 cycles, then release -> all outputs 0 during rst; k_ready=1 one cycle after release.
//  2. WORD_W=16, KEY_WORDS=4, ROUNDS=32, Z_IDX=0; key=64'h1918_1110_0908_0100; rk_ready=1.
//     - k[0..3] = 0100,0908,1110,1918.
//     - All 32 keys match the golden C model.
//     - rk_last only at index 31.
//     - First key 1 cycle after accept; 32 contiguous beats.
//  3. WORD_W=32, KEY_WORDS=4, ROUNDS=44, Z_IDX=3; key=128'h1b1a1918_13121110_0b0a0908_03020100.
//     - rk_ready toggles pseudo-randomly.
//     - 44 keys match the model.
//     - rk_data/rk_index are stable across every stall cycle.
//  4. k_valid held high during RUN with a different key -> key ignored.
//     - The stream completes with the original key; the second key is accepted only after rk_last.
//  5. abort at rk_index=10 coincident with a beat.
//     - Key 10 is consumed; rk_valid=0 next cycle; k_ready=1.
//     - A fresh key then streams from index 0.
//  6. rst asserted at rk_index=5.
//     - Outputs return to reset values.
//     - A new key after release produces a correct full stream.

Source files
------------

// File: rtl/simon_kexp_stream_if.sv
// Bundle of the master-key input port and the round-key output stream of the
// Simon key-schedule generator.
//
// Handshake rule for both channels (key: k_valid/k_ready, round key:
// rk_valid/rk_ready): a transfer happens on a rising clock edge where valid
// and ready are both high; once valid is raised the payload stays stable
// until that transfer, and ready may be raised or dropped at any time
// without affecting the payload.
interface simon_kexp_stream_if #(
  parameter int WORD_W    = 32,
  parameter int KEY_WORDS = 4
);
  logic [WORD_W*KEY_WORDS-1:0] key;
  logic                        k_valid;
  logic                        k_ready;
  logic                        abort;
  logic [WORD_W-1:0]           rk_data;
  logic [6:0]                  rk_index;
  logic                        rk_valid;
  logic                        rk_ready;
  logic                        rk_last;
  logic                        state_dbg;  // 0 = IDLE, 1 = RUN

  // Key-schedule block side.
  modport master (
    input  key, k_valid, abort, rk_ready,
    output k_ready, rk_data, rk_index, rk_valid, rk_last, state_dbg
  );

  // Key source / round-key consumer side.
  modport slave (
    output key, k_valid, abort, rk_ready,
    input  k_ready, rk_data, rk_index, rk_valid, rk_last, state_dbg
  );
endinterface

// File: rtl/simon_kexp_stream.sv
// Iterative Simon key schedule. Holds a KEY_WORDS-deep sliding window of
// round-key words; window slot 0 is the key currently offered on the stream
// and each accepted beat shifts in the next schedule word.
module simon_kexp_stream #(
  parameter int WORD_W    = 32,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 44,
  parameter int Z_IDX     = 3
) (
  input  logic                 ck,
  input  logic                 rst,
  simon_kexp_stream_if.master  bus
);

  localparam bit LEGAL =
    ((WORD_W == 16 && KEY_WORDS == 4) ||
     (WORD_W == 24 && (KEY_WORDS == 3 || KEY_WORDS == 4)) ||
     (WORD_W == 32 && (KEY_WORDS == 3 || KEY_WORDS == 4)) ||
     (WORD_W == 48 && (KEY_WORDS == 2 || KEY_WORDS == 3)) ||
     (WORD_W == 64 && KEY_WORDS >= 2 && KEY_WORDS <= 4)) &&
    (ROUNDS >= KEY_WORDS) && (ROUNDS <= 72) &&
    (Z_IDX >= 0) && (Z_IDX <= 4);

  if (!LEGAL) begin : g_illegal
    $error("simon_kexp_stream: illegal WORD_W/KEY_WORDS/ROUNDS/Z_IDX combination");
  end

  // z sequences, first published bit in bit 61.
  function automatic logic [61:0] z_seq(input int j);
    case (j)
      0:       z_seq = 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       z_seq = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       z_seq = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       z_seq = 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: z_seq = 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  localparam logic [61:0] Z     = z_seq(Z_IDX);
  localparam logic [6:0]  LAST  = 7'(ROUNDS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              ready_q;
  logic [WORD_W-1:0] win [KEY_WORDS];
  logic [6:0]        idx;
  logic [5:0]        zptr;
  logic              beat, is_last, key_take, z_bit;
  logic [WORD_W-1:0] t_rot, t_mix, next_word;

  assign beat     = (state == RUN) && bus.rk_ready;
  assign is_last  = (idx == LAST);
  assign key_take = (state == IDLE) && bus.k_valid && ready_q;
  assign z_bit    = Z[6'd61 - zptr];

  assign bus.k_ready   = ready_q;
  assign bus.rk_valid  = (state == RUN);
  assign bus.rk_data   = win[0];
  assign bus.rk_index  = idx;
  assign bus.rk_last   = (state == RUN) && is_last;
  assign bus.state_dbg = logic'(state);

  // Next schedule word k[i+m] from the window holding k[i..i+m-1].
  always_comb begin
    t_rot = {win[KEY_WORDS-1][2:0], win[KEY_WORDS-1][WORD_W-1:3]};
    if (KEY_WORDS == 4) t_rot = t_rot ^ win[1];
    t_mix     = t_rot ^ {t_rot[0], t_rot[WORD_W-1:1]};
    next_word = ~win[0] ^ t_mix ^ WORD_W'(z_bit) ^ WORD_W'(3);
  end

  // Next-state: leave IDLE on key accept; leave RUN on abort or final beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (key_take) state_nxt = RUN;
      RUN:  if (bus.abort || (beat && is_last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered k_ready (kept low throughout reset).
  always_ff @(posedge ck) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == IDLE);
    end
  end

  // Window load on key accept, shift on every non-final beat.
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int j = 0; j < KEY_WORDS; j++) win[j] <= '0;
      idx  <= '0;
      zptr <= '0;
    end else if (key_take) begin
      for (int j = 0; j < KEY_WORDS; j++) win[j] <= bus.key[j*WORD_W +: WORD_W];
      idx  <= '0;
      zptr <= '0;
    end else if (beat && !is_last) begin
      for (int j = 0; j < KEY_WORDS - 1; j++) win[j] <= win[j+1];
      win[KEY_WORDS-1] <= next_word;
      idx  <= idx + 7'd1;
      zptr <= (zptr == 6'd61) ? 6'd0 : zptr + 6'd1;
    end
  end

endmodule

// File: tb/tb_simon_kexp_stream.sv
// Bench for simon_kexp_stream: a Simon32/64 instance (a) and a Simon64/128
// instance (b). Expected round keys come from a behavioural key-schedule
// model and sit in per-instance queues; monitors pop them on every beat.
// The streamed keys also drive a reference Simon encryption whose result is
// compared with the published ciphertexts.
module tb_simon_kexp_stream;

  logic ck;
  logic rst;

  simon_kexp_stream_if #(.WORD_W(16), .KEY_WORDS(4)) a_if();
  simon_kexp_stream_if #(.WORD_W(32), .KEY_WORDS(4)) b_if();

  simon_kexp_stream #(.WORD_W(16), .KEY_WORDS(4), .ROUNDS(32), .Z_IDX(0))
    dut_a (.ck(ck), .rst(rst), .bus(a_if));
  simon_kexp_stream #(.WORD_W(32), .KEY_WORDS(4), .ROUNDS(44), .Z_IDX(3))
    dut_b (.ck(ck), .rst(rst), .bus(b_if));

  // entry = {last, index[6:0], data[31:0]}
  logic [39:0] exp_a[$];
  logic [39:0] exp_b[$];

  int n_checks = 0;
  int n_errors = 0;
  bit b_rand   = 0;
  logic [31:0] cx_a, cy_a, cx_b, cy_b;

  // ---------------- clock / reset ----------------
  initial begin
    ck = 0;
    forever #5 ck = ~ck;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
    logic [63:0] m = (64'd1 << n) - 1;
    return ((x >> r) | (x << (n - r))) & m;
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] x, input int r, input int n);
    logic [63:0] m = (64'd1 << n) - 1;
    return ((x << r) | (x >> (n - r))) & m;
  endfunction

  function automatic logic [63:0] zbit(input int j, input int i);
    string s;
    case (j)
      0: s = "11111010001001010110000111001101111101000100101011000011100110";
      1: s = "10001110111110010011000010110101000111011111001001100001011010";
      2: s = "10101111011100000011010010011000101000010001111110010110110011";
      3: s = "11011011101011000110010111100000010010001010011100110100001111";
      default: s = "11010001111001101011011000100000010111000011001010010011101111";
    endcase
    return (s[i] == "1") ? 64'd1 : 64'd0;
  endfunction

  task automatic push_exp(input int which, input logic [127:0] key,
                          input int n, input int m, input int rounds, input int zj);
    logic [63:0] k[80];
    logic [63:0] mask = (64'd1 << n) - 1;
    logic [63:0] t;
    for (int w = 0; w < m; w++) k[w] = 64'(key >> (w * n)) & mask;
    for (int i = 0; i + m < rounds; i++) begin
      t = ror(k[i+m-1], 3, n);
      if (m == 4) t = t ^ k[i+1];
      t = t ^ ror(t, 1, n);
      k[i+m] = (~k[i] & mask) ^ t ^ zbit(zj, i % 62) ^ 64'd3;
    end
    for (int r = 0; r < rounds; r++) begin
      if (which == 0) exp_a.push_back({r == rounds - 1, 7'(r), k[r][31:0]});
      else            exp_b.push_back({r == rounds - 1, 7'(r), k[r][31:0]});
    end
  endtask

  function automatic logic [63:0] simon_f(input logic [63:0] x, input int n);
    return (rol(x, 1, n) & rol(x, 8, n)) ^ rol(x, 2, n);
  endfunction

  // ---------------- consumers / monitors ----------------
  initial begin
    b_if.rk_ready = 1'b1;
    forever begin
      @(posedge ck);
      #1 b_if.rk_ready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic [39:0] e;
    logic [31:0] t;
    forever begin
      @(negedge ck);
      if (!rst && a_if.rk_valid === 1'b1 && a_if.rk_ready === 1'b1) begin
        if (exp_a.size() == 0) check("a_unexpected_beat", 1, 0);
        else begin
          e = exp_a.pop_front();
          check("a_rk_data", a_if.rk_data, e[15:0]);
          check("a_rk_index", a_if.rk_index, e[38:32]);
          check("a_rk_last", a_if.rk_last, e[39]);
          t = cx_a;
          cx_a = 32'(cy_a ^ simon_f(cx_a, 16) ^ a_if.rk_data);
          cy_a = t;
        end
      end
    end
  end

  initial begin
    logic [39:0] e;
    logic [31:0] t, h_data;
    logic [6:0]  h_idx;
    bit hold = 0;
    forever begin
      @(negedge ck);
      if (rst) hold = 0;
      else if (b_if.rk_valid === 1'b1) begin
        if (hold) begin
          check("b_stall_data", b_if.rk_data, h_data);
          check("b_stall_index", b_if.rk_index, h_idx);
        end
        if (b_if.rk_ready) begin
          hold = 0;
          if (exp_b.size() == 0) check("b_unexpected_beat", 1, 0);
          else begin
            e = exp_b.pop_front();
            check("b_rk_data", b_if.rk_data, e[31:0]);
            check("b_rk_index", b_if.rk_index, e[38:32]);
            check("b_rk_last", b_if.rk_last, e[39]);
            t = cx_b;
            cx_b = 32'(cy_b ^ simon_f(cx_b, 32) ^ b_if.rk_data);
            cy_b = t;
          end
        end else begin
          hold = 1;
          h_data = b_if.rk_data;
          h_idx  = b_if.rk_index;
        end
      end else hold = 0;
    end
  end

  // ---------------- driver tasks (instance b) ----------------
  task automatic wait_ready_b(input int limit);
    bit ok = 0;
    for (int c = 0; c < limit; c++) begin
      if (b_if.k_ready) begin ok = 1; break; end
      @(posedge ck); #1;
    end
    check("b_k_ready_timeout", ok, 1);
  endtask

  task automatic send_key_b(input logic [127:0] key);
    b_if.key = key;
    b_if.k_valid = 1'b1;
    wait_ready_b(50);
    @(posedge ck); #1;
    b_if.k_valid = 1'b0;
  endtask

  task automatic wait_drain_b(input int limit);
    bit ok = 0;
    for (int c = 0; c < limit; c++) begin
      if (exp_b.size() == 0 && !b_if.rk_valid) begin ok = 1; break; end
      @(posedge ck); #1;
    end
    check("b_drain_timeout", ok, 1);
  endtask

  task automatic wait_index_b(input int target);
    bit ok = 0;
    for (int c = 0; c < 500; c++) begin
      if (b_if.rk_valid && b_if.rk_index == 7'(target)) begin ok = 1; break; end
      @(posedge ck); #1;
    end
    check("b_index_timeout", ok, 1);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] KEY_B = 128'h1b1a1918_13121110_0b0a0908_03020100;

  initial begin
    logic [127:0] k2;
    rst = 1'b1;
    a_if.key = '0; a_if.k_valid = 0; a_if.abort = 0; a_if.rk_ready = 1'b1;
    b_if.key = '0; b_if.k_valid = 0; b_if.abort = 0;

    // 1. reset values, k_ready one cycle after release
    repeat (3) @(posedge ck);
    #1;
    check("rst_a_k_ready", a_if.k_ready, 0);
    check("rst_a_rk_valid", a_if.rk_valid, 0);
    check("rst_a_rk_last", a_if.rk_last, 0);
    check("rst_a_rk_index", a_if.rk_index, 0);
    check("rst_a_rk_data", a_if.rk_data, 0);
    check("rst_b_k_ready", b_if.k_ready, 0);
    check("rst_b_rk_valid", b_if.rk_valid, 0);
    check("rst_b_rk_data", b_if.rk_data, 0);
    rst = 1'b0;
    @(posedge ck); #1;
    check("rel_a_k_ready", a_if.k_ready, 1);
    check("rel_b_k_ready", b_if.k_ready, 1);

    // 2. Simon32/64, full-rate consumer, 32 contiguous beats
    push_exp(0, 128'h1918_1110_0908_0100, 16, 4, 32, 0);
    cx_a = 32'h6565; cy_a = 32'h6877;
    a_if.key = 64'h1918_1110_0908_0100;
    a_if.k_valid = 1'b1;
    @(posedge ck); #1;
    a_if.k_valid = 1'b0;
    for (int c = 0; c < 32; c++) begin
      check("a_contig_valid", a_if.rk_valid, 1);
      check("a_contig_index", a_if.rk_index, c);
      @(posedge ck); #1;
    end
    check("a_end_valid", a_if.rk_valid, 0);
    check("a_end_k_ready", a_if.k_ready, 1);
    check("a_queue_empty", exp_a.size(), 0);
    check("a_ciphertext", {cx_a[15:0], cy_a[15:0]}, 32'hc69b_e9bb);

    // 3. Simon64/128 with random backpressure
    b_rand = 1;
    push_exp(1, KEY_B, 32, 4, 44, 3);
    cx_b = 32'h656b696c; cy_b = 32'h20646e75;
    send_key_b(KEY_B);
    wait_drain_b(2000);
    check("b_ciphertext", {cx_b, cy_b}, 64'h44c8fc20_b9dfa07a);

    // 4. second key held valid during RUN is ignored until the stream ends
    k2 = {$urandom, $urandom, $urandom, $urandom};
    push_exp(1, KEY_B, 32, 4, 44, 3);
    push_exp(1, k2, 32, 4, 44, 3);
    send_key_b(KEY_B);
    check("b_run_k_ready", b_if.k_ready, 0);
    b_if.key = k2;
    b_if.k_valid = 1'b1;
    wait_ready_b(2000);
    check("b_second_key_after_last", exp_b.size(), 44);
    @(posedge ck); #1;
    b_if.k_valid = 1'b0;
    wait_drain_b(2000);

    // 5. abort coincident with the beat of index 10
    b_rand = 0;
    @(posedge ck); #1;
    push_exp(1, k2, 32, 4, 44, 3);
    send_key_b(k2);
    wait_index_b(10);
    b_if.abort = 1'b1;
    @(posedge ck); #1;
    b_if.abort = 1'b0;
    check("abort_rk_valid", b_if.rk_valid, 0);
    check("abort_k_ready", b_if.k_ready, 1);
    check("abort_consumed", exp_b.size(), 33);
    exp_b.delete();
    b_if.abort = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    b_if.abort = 1'b0;
    check("idle_abort_rk_valid", b_if.rk_valid, 0);
    check("idle_abort_k_ready", b_if.k_ready, 1);
    push_exp(1, KEY_B, 32, 4, 44, 3);
    send_key_b(KEY_B);
    check("fresh_first_index", b_if.rk_index, 0);
    check("fresh_first_valid", b_if.rk_valid, 1);
    wait_drain_b(2000);

    // 6. reset at index 5, then a clean stream
    b_rand = 1;
    push_exp(1, k2, 32, 4, 44, 3);
    send_key_b(k2);
    wait_index_b(5);
    rst = 1'b1;
    repeat (2) @(posedge ck);
    #1;
    check("mid_rst_rk_valid", b_if.rk_valid, 0);
    check("mid_rst_k_ready", b_if.k_ready, 0);
    check("mid_rst_rk_last", b_if.rk_last, 0);
    check("mid_rst_rk_index", b_if.rk_index, 0);
    check("mid_rst_rk_data", b_if.rk_data, 0);
    rst = 1'b0;
    exp_b.delete();
    @(posedge ck); #1;
    check("mid_rel_k_ready", b_if.k_ready, 1);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    push_exp(1, k2, 32, 4, 44, 3);
    send_key_b(k2);
    wait_drain_b(2000);

    repeat (3) @(posedge ck);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
